// File: rtl/cond_code_unit.sv
// rtl/cond_code_unit.sv - Y-86 condition-code register and condition evaluator.
// Optional same-edge flag forwarding: define COND_CODE_UNIT_BYPASS_EN.
module cond_code_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [1:0]  alu_fun,
   input  logic [63:0] alu_result,
   input  logic        cout_add,
   input  logic        cout_sub,
   input  logic        ovf_add,
   input  logic        ovf_sub,
   input  logic        set_cc,
   input  logic        except_pending,
   input  logic        stall,
   input  logic        cond_req,
   input  logic [3:0]  cond_fun,
   output logic        zf,
   output logic        sf,
   output logic        of,
   output logic        cnd,
   output logic        cnd_valid,
   output logic        cnd_err,
   output logic [15:0] cc_wr_cnt
);

   logic        zf_q, sf_q, of_q, zf_d, sf_d, of_d;
   logic        cnd_q, cnd_valid_q, cnd_err_q, cnd_d, cnd_valid_d, cnd_err_d;
   logic [15:0] cnt_q, cnt_d;
   logic        wr_en, eval_en;
   logic        new_zf, new_sf, new_of;
   logic        ev_zf, ev_sf, ev_of, ev_cnd, ev_err;
   logic        unused_carry;

   // Carry-outs are visible at the boundary but not architectural state in Y-86.
   assign unused_carry = cout_add ^ cout_sub;

   assign wr_en   = alu_valid & set_cc & ~except_pending & ~stall;
   assign eval_en = cond_req & ~stall;
   assign new_zf  = (alu_result == 64'd0);
   assign new_sf  = alu_result[63];

   always_comb begin
      new_of = 1'b0;
      case (alu_fun)
         2'b00:   new_of = ovf_add;
         2'b01:   new_of = ovf_sub;
         default: new_of = 1'b0;
      endcase
   end

`ifdef COND_CODE_UNIT_BYPASS_EN
   assign ev_zf = wr_en ? new_zf : zf_q;
   assign ev_sf = wr_en ? new_sf : sf_q;
   assign ev_of = wr_en ? new_of : of_q;
`else
   assign ev_zf = zf_q;
   assign ev_sf = sf_q;
   assign ev_of = of_q;
`endif

   always_comb begin
      ev_cnd = 1'b0;
      ev_err = 1'b0;
      case (cond_fun)
         4'd0:    ev_cnd = 1'b1;
         4'd1:    ev_cnd = (ev_sf ^ ev_of) | ev_zf;
         4'd2:    ev_cnd = ev_sf ^ ev_of;
         4'd3:    ev_cnd = ev_zf;
         4'd4:    ev_cnd = ~ev_zf;
         4'd5:    ev_cnd = ~(ev_sf ^ ev_of);
         4'd6:    ev_cnd = ~(ev_sf ^ ev_of) & ~ev_zf;
         default: ev_err = 1'b1;
      endcase
   end

   always_comb begin
      zf_d        = wr_en ? new_zf : zf_q;
      sf_d        = wr_en ? new_sf : sf_q;
      of_d        = wr_en ? new_of : of_q;
      cnt_d       = wr_en ? cnt_q + 16'd1 : cnt_q;
      cnd_d       = eval_en ? ev_cnd : cnd_q;
      cnd_err_d   = eval_en ? ev_err : cnd_err_q;
      cnd_valid_d = stall ? cnd_valid_q : cond_req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zf_q        <= 1'b1;
         sf_q        <= 1'b0;
         of_q        <= 1'b0;
         cnd_q       <= 1'b0;
         cnd_valid_q <= 1'b0;
         cnd_err_q   <= 1'b0;
         cnt_q       <= 16'd0;
      end else begin
         zf_q        <= zf_d;
         sf_q        <= sf_d;
         of_q        <= of_d;
         cnd_q       <= cnd_d;
         cnd_valid_q <= cnd_valid_d;
         cnd_err_q   <= cnd_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign zf        = zf_q;
   assign sf        = sf_q;
   assign of        = of_q;
   assign cnd       = cnd_q;
   assign cnd_valid = cnd_valid_q;
   assign cnd_err   = cnd_err_q;
   assign cc_wr_cnt = cnt_q;

endmodule
